// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller on the CPU data-memory port: switch/LED banks,
// debounced buttons with sticky press events, segment word and a cycle timer.
module mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'hffff_ff00,
  parameter int unsigned SW_W         = 8,
  parameter int unsigned N_SW         = 2,
  parameter int unsigned LED_W        = 8,
  parameter int unsigned N_LED        = 2,
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned DEBOUNCE_CYC = 200000,
  parameter logic [31:0] SEG_RESET    = 32'h01abcdef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            Address,
  input  logic [31:0]            WriteData,
  input  logic                   MemWrite,
  input  logic                   MemRead,
  input  logic [N_SW*SW_W-1:0]   sw_in,
  input  logic [N_BTN-1:0]       btn_in,
  output logic [N_LED*LED_W-1:0] led_out,
  output logic [31:0]            seg_out,
  output logic [31:0]            DataIo
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]       OFF_BTN  = 8'h10;
  localparam logic [7:0]       OFF_EVT  = 8'h14;
  localparam logic [7:0]       OFF_SEG  = 8'h30;
  localparam logic [7:0]       OFF_TMR  = 8'h34;

  logic       hit;
  logic [7:0] off;
  logic       wr_en;

  assign hit   = (Address[31:8] == BASE_ADDR[31:8]) && (Address[1:0] == 2'b00);
  assign off   = Address[7:0];
  assign wr_en = MemWrite && hit;

  // Switch synchroniser
  logic [N_SW*SW_W-1:0] sw_s1, sw_s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

  // Button synchroniser, debounce counters, levels and sticky events
  logic [N_BTN-1:0] btn_s1, btn_s2, btn_lvl, btn_evt;
  logic [N_BTN-1:0] btn_rise, evt_clr;
  logic [CNT_W-1:0] btn_cnt [N_BTN];

  // A rise is the cycle a low level is about to be accepted as high.
  always_comb begin
    btn_rise = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      btn_rise[k] = btn_s2[k] && !btn_lvl[k] && (btn_cnt[k] == CNT_LAST);
    end
  end

  always_comb begin
    evt_clr = '0;
    if (hit && (off == OFF_EVT)) begin
      if (MemRead)  evt_clr = evt_clr | btn_evt;
      if (MemWrite) evt_clr = evt_clr | WriteData[N_BTN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_lvl <= '0;
      btn_evt <= '0;
      for (int unsigned k = 0; k < N_BTN; k++) begin
        btn_cnt[k] <= '0;
      end
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      for (int unsigned k = 0; k < N_BTN; k++) begin
        if (btn_s2[k] == btn_lvl[k]) begin
          btn_cnt[k] <= '0;
        end else if (btn_cnt[k] == CNT_LAST) begin
          btn_lvl[k] <= btn_s2[k];
          btn_cnt[k] <= '0;
        end else begin
          btn_cnt[k] <= btn_cnt[k] + CNT_W'(1);
        end
      end
      // Set after clear so a same-cycle rising edge survives the clear.
      btn_evt <= (btn_evt & ~evt_clr) | btn_rise;
    end
  end

  // Writable registers: LED banks, segment word, timer
  logic [N_LED*LED_W-1:0] led_q;
  logic [31:0]            seg_q;
  logic [31:0]            timer_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q   <= '0;
      seg_q   <= SEG_RESET;
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
      if (wr_en) begin
        for (int unsigned j = 0; j < N_LED; j++) begin
          if (off == 8'(32'h20 + 4 * j)) begin
            led_q[j*LED_W +: LED_W] <= WriteData[LED_W-1:0];
          end
        end
        if (off == OFF_SEG) seg_q   <= WriteData;
        if (off == OFF_TMR) timer_q <= WriteData;
      end
    end
  end

  assign led_out = led_q;
  assign seg_out = seg_q;

  // Read mux, purely combinational and independent of MemRead
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit) begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        if (off == 8'(4 * i)) rdata[SW_W-1:0] = sw_s2[i*SW_W +: SW_W];
      end
      for (int unsigned j = 0; j < N_LED; j++) begin
        if (off == 8'(32'h20 + 4 * j)) rdata[LED_W-1:0] = led_q[j*LED_W +: LED_W];
      end
      case (off)
        OFF_BTN: rdata[N_BTN-1:0] = btn_lvl;
        OFF_EVT: rdata[N_BTN-1:0] = btn_evt;
        OFF_SEG: rdata = seg_q;
        OFF_TMR: rdata = timer_q;
        default: ;
      endcase
    end
  end

  assign DataIo = rdata;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl: directed scenarios with literal expectations, then
// randomized bus/switch/button traffic checked every cycle against a model.
module tb_mmio_ctrl;

  localparam int unsigned SW_W  = 8;
  localparam int unsigned N_SW  = 2;
  localparam int unsigned LED_W = 8;
  localparam int unsigned N_LED = 2;
  localparam int unsigned N_BTN = 5;
  localparam int unsigned DEB   = 4;
  localparam logic [31:0] BASE    = 32'hffff_ff00;
  localparam logic [31:0] SEG_RST = 32'h01abcdef;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic [15:0] led_out;
  logic [31:0] seg_out, DataIo;

  always #10 clk = ~clk;

  mmio_ctrl #(
    .BASE_ADDR(BASE), .SW_W(SW_W), .N_SW(N_SW), .LED_W(LED_W), .N_LED(N_LED),
    .N_BTN(N_BTN), .DEBOUNCE_CYC(DEB), .SEG_RESET(SEG_RST)
  ) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .sw_in(sw_in), .btn_in(btn_in),
    .led_out(led_out), .seg_out(seg_out), .DataIo(DataIo)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_valid = 1'b0;
  logic [15:0] sw_q[$];      // raw switch samples, oldest visible
  logic [4:0]  bq[$];        // raw button samples awaiting synchronisation
  logic [4:0]  bs_hist[$];   // last DEB synchronised button samples
  logic [4:0]  m_lvl, m_ev;
  logic [7:0]  m_led [N_LED];
  logic [31:0] m_seg, m_timer;

  function automatic bit in_win(input logic [31:0] a);
    return (a[31:8] == BASE[31:8]) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned o;
    logic [15:0] v;
    o = a[7:0];
    if (!in_win(a)) return 32'h0;
    if (o < 32'h10) begin
      v = sw_q[0];
      if (o / 4 < N_SW) return 32'((v >> (8 * (o / 4))) & 16'h00ff);
      return 32'h0;
    end
    if (o >= 32'h20 && o < 32'h20 + 4 * N_LED) return {24'h0, m_led[(o - 32'h20) / 4]};
    case (o)
      32'h10:  return {27'h0, m_lvl};
      32'h14:  return {27'h0, m_ev};
      32'h30:  return m_seg;
      32'h34:  return m_timer;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [4:0]  bs, rise, clr;
    int unsigned o;
    bit          w, r, all_diff;
    if (reset === 1'b0) begin
      model_valid = 1'b1;
      sw_q = '{16'h0, 16'h0};
      bq   = '{5'h0, 5'h0};
      bs_hist = {};
      repeat (DEB) bs_hist.push_back(5'h0);
      m_lvl = '0;
      m_ev  = '0;
      foreach (m_led[j]) m_led[j] = '0;
      m_seg   = SEG_RST;
      m_timer = '0;
    end else if (model_valid) begin
      o = Address[7:0];
      w = MemWrite && in_win(Address);
      r = MemRead && in_win(Address);
      clr = '0;
      if (r && o == 32'h14) clr = clr | m_ev;
      if (w && o == 32'h14) clr = clr | WriteData[4:0];
      m_timer = (w && o == 32'h34) ? WriteData : m_timer + 32'd1;
      if (w && o == 32'h30) m_seg = WriteData;
      if (w && o >= 32'h20 && o < 32'h20 + 4 * N_LED) m_led[(o - 32'h20) / 4] = WriteData[7:0];
      sw_q.push_back(sw_in);
      void'(sw_q.pop_front());
      bs = bq[0];
      bq.push_back(btn_in);
      void'(bq.pop_front());
      bs_hist.push_back(bs);
      void'(bs_hist.pop_front());
      // A level flips once the last DEB synchronised samples all disagree with it.
      rise = '0;
      for (int k = 0; k < int'(N_BTN); k++) begin
        all_diff = 1'b1;
        foreach (bs_hist[i]) if (bs_hist[i][k] == m_lvl[k]) all_diff = 1'b0;
        if (all_diff) begin
          if (!m_lvl[k]) rise[k] = 1'b1;
          m_lvl[k] = ~m_lvl[k];
        end
      end
      m_ev = (m_ev & ~clr) | rise;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cmp_led_out", {16'h0, led_out}, {16'h0, m_led[1], m_led[0]});
      chk("cmp_seg_out", seg_out, m_seg);
      chk("cmp_DataIo", DataIo, model_read(Address));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [7:0] o, input logic [31:0] exp, input string name);
    Address = BASE | {24'h0, o};
    #1;
    chk(name, DataIo, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    cyc(1);
    MemWrite  = 1'b0;
  endtask

  logic [31:0] offs [15] = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18,
                             32'h20, 32'h24, 32'h28, 32'h2c, 32'h30, 32'h34, 32'h38, 32'hfc};

  initial begin
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    sw_in = '0; btn_in = '0;
    cyc(3);
    reset = 1'b1;
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_seg", seg_out, 32'h01abcdef);
    peek(8'h34, 32'h0, "timer_t0");
    cyc(1); peek(8'h34, 32'h1, "timer_t1");
    cyc(1); peek(8'h34, 32'h2, "timer_t2");

    sw_in = 16'h3ca5;
    cyc(1); peek(8'h00, 32'h0, "sw_one_edge");
    cyc(1); peek(8'h00, 32'ha5, "sw_bank0");
    peek(8'h04, 32'h3c, "sw_bank1");
    peek(8'h08, 32'h0, "sw_bank2_absent");

    btn_in = 5'h01; cyc(3); btn_in = 5'h00; cyc(6);
    peek(8'h10, 32'h0, "glitch_level");
    peek(8'h14, 32'h0, "glitch_event");
    btn_in = 5'h01; cyc(8);
    peek(8'h10, 32'h1, "press_level");
    peek(8'h14, 32'h1, "press_event");

    Address = BASE | 32'h14; MemRead = 1'b1;
    peek(8'h14, 32'h1, "rtc_read");
    cyc(1); MemRead = 1'b0;
    peek(8'h14, 32'h0, "rtc_after");

    btn_in = 5'h03; cyc(8);
    peek(8'h14, 32'h2, "btn1_event");
    btn_in = 5'h07; cyc(5);
    Address = BASE | 32'h14; MemRead = 1'b1;
    peek(8'h14, 32'h2, "clr_read_pre");
    cyc(1); MemRead = 1'b0;
    peek(8'h14, 32'h4, "rise_beats_clear");
    peek(8'h10, 32'h7, "levels_012");
    wr(BASE | 32'h14, 32'h4);
    peek(8'h14, 32'h0, "w1c_clear");

    wr(BASE | 32'h24, 32'h123456ff);
    chk("led1_write", {16'h0, led_out}, 32'h0000ff00);
    peek(8'h24, 32'hff, "led1_readback");
    Address = BASE | 32'h24; WriteData = 32'h11; cyc(1);
    chk("led_no_strobe", {16'h0, led_out}, 32'h0000ff00);
    wr(BASE | 32'h26, 32'h22);
    chk("led_misaligned", {16'h0, led_out}, 32'h0000ff00);
    peek(8'h26, 32'h0, "misaligned_read");
    wr(BASE | 32'h00, 32'hffffffff);
    peek(8'h00, 32'ha5, "ro_write_ignored");
    wr(BASE | 32'h30, 32'hdeadbeef);
    chk("seg_write", seg_out, 32'hdeadbeef);

    wr(BASE | 32'h34, 32'hfffffffe);
    peek(8'h34, 32'hfffffffe, "timer_load");
    cyc(1); peek(8'h34, 32'hffffffff, "timer_max");
    cyc(1); peek(8'h34, 32'h00000000, "timer_wrap");

    repeat (4000) begin
      reset     = ($urandom_range(0, 499) != 0);
      MemWrite  = ($urandom_range(0, 3) == 0);
      MemRead   = ($urandom_range(0, 2) == 0);
      WriteData = $urandom;
      Address   = BASE | offs[$urandom_range(0, 14)];
      if ($urandom_range(0, 7) == 0) Address = Address + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) Address = Address ^ 32'h0000_0100;
      if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom);
      for (int k = 0; k < int'(N_BTN); k++) begin
        if ($urandom_range(0, 9) == 0) btn_in[k] = ~btn_in[k];
      end
      cyc(1);
    end
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
Parametrised memory-mapped I/O controller on the pipeline CPU's data-memory port. It replaces the fixed two-switch/two-LED/one-button MMIO. It adds:
- N switch banks and N LED banks.
- Synchronised inputs and debounced buttons with sticky read-to-clear press events.
- LED/segment readback and a free-running cycle timer.
- Explicit read/write strobes.

It sits beside data memory. The memory stage muxes DataIo in for addresses in the MMIO window.

Parameters:
BASE_ADDR, 32'hffff_ff00, window base; upper 24 bits select MMIO, Address[7:0] is the offset
SW_W, 8, bits per switch bank
N_SW, 2, switch banks (1..4)
LED_W, 8, bits per LED bank
N_LED, 2, LED banks (1..4)
N_BTN, 5, buttons (1..8)
DEBOUNCE_CYC, 200000, consecutive stable cycles required to accept a button change (>=2)
SEG_RESET, 32'h01abcdef, segment register reset value

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
Address  in  32  byte address from memory stage
WriteData  in  32  store data
MemWrite  in  1  store strobe; registers update only when high
MemRead  in  1  load strobe; qualifies read-to-clear side effects
sw_in  in  N_SW*SW_W  raw switches, bank i = bits [i*SW_W +: SW_W]
btn_in  in  N_BTN  raw buttons, active-high
led_out  out  N_LED*LED_W  LED banks, same packing as sw_in
seg_out  out  32  segment display word
DataIo  out  32  combinational read data

Behaviour:
- Hit: Address[31:8]==BASE_ADDR[31:8] and Address[1:0]==0. Misses read 0 and writes are ignored.
- Offset map:
  - 0x00+4i: switch bank i (RO), zero-extended. Valid for i<N_SW; otherwise reads 0.
  - 0x10: debounced button levels (RO), bits[N_BTN-1:0].
  - 0x14: press events (R/W1C).
  - 0x20+4j: LED bank j (RW), low LED_W bits. Valid for j<N_LED.
  - 0x30: segment word (RW).
  - 0x34: cycle timer (RW).
  - All other offsets: read 0, writes ignored.
- Reset (reset==0 at posedge), every state element:
  - led_out=0, seg_out=SEG_RESET, timer=0.
  - Sync flops, debounce counters, debounced levels and events all 0.
  - Reset mid-debounce discards the count.
- Reads: DataIo is purely combinational from Address and current state. Zero-latency, independent of MemRead.
- Switch path: 2-flop synchroniser. A change on sw_in is visible on DataIo at the 2nd posedge after the change.
- Button path, per button:
  - 2-flop synchroniser, then a counter.
  - While sync != level, the counter increments; when sync==level, the counter clears.
  - When the counter reaches DEBOUNCE_CYC-1 with sync still != level, level <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes level.
- Events:
  - A 0->1 transition of level[k] sets event[k].
  - Bits stay set until cleared by either a MemRead at 0x14, which clears all bits that read 1 that cycle, or a MemWrite at 0x14, which clears bits where WriteData[k]=1.
  - A new rising edge in the same cycle as a clear wins: the bit stays 1.
- Writes (MemWrite=1, hit) take effect at the posedge; readback shows the new value the next cycle.
  - LED j <= WriteData[LED_W-1:0].
  - Segment <= WriteData.
  - Timer <= WriteData. No increment that cycle.
- Timer: otherwise increments by 1 every cycle and wraps 32'hffffffff -> 0.
- MemWrite and MemRead both high: the write is performed. DataIo shows the pre-write value. For 0x14, both clear sources OR together.
- MemWrite to an RO offset: no effect.
- led_out and seg_out are direct register outputs. No glitch on unrelated writes.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release. Expect led_out=0, seg_out=32'h01abcdef, DataIo@0x34 counting 0,1,2… from release.
- Switch: set sw_in={8'h3c,8'ha5}, wait 2 cycles. Expect DataIo@0xffffff00=32'h000000a5 and @0xffffff04=32'h0000003c. Expect @0xffffff08=0 with N_SW=2.
- Debounce (DEBOUNCE_CYC=4):
  - Pulse btn_in[0] high for 3 cycles: level@0x10 stays 0 and event@0x14 stays 0.
  - Hold high for 8 cycles: level bit0=1, and event reads 32'h1.
- Read-to-clear:
  - MemRead@0x14 returns 1, next read returns 0.
  - A new debounced rising edge on btn 2 in the same cycle as the clearing read leaves event=32'h4.
- LED/seg writes:
  - MemWrite@0xffffff24 WriteData=32'h123456ff: led_out[15:8]=8'hff and readback=32'h000000ff.
  - Write with MemWrite=0: no change.
  - Write @0xffffff26 (misaligned): ignored.
- Timer wrap: write 32'hfffffffe to 0x34. Next cycles read fffffffe, ffffffff, 00000000.
